// File: rtl/seed_ks_byte_arith.sv
// Byte-serial SEED key-schedule arithmetic: K0 = A + C - KC or K1 = B - D + KC (mod 2^32),
// one operand byte in and one result byte out per beat, LSB first.
module seed_ks_byte_arith (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sel,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic [7:0] kc_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic       busy
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t     r_state;
    logic       r_sel;
    logic       r_c;
    logic       r_b;
    logic [1:0] r_cnt;
    logic       r_out_valid;
    logic [7:0] r_out_byte;
    logic       r_out_last;

    logic       w_accept;
    logic [8:0] w_t;
    logic [8:0] w_u;
    logic [7:0] w_res;

    // Two chained 9-bit stages; bit 8 of each stage is the carry/borrow for the next byte.
    always_comb begin
        w_t   = '0;
        w_u   = '0;
        w_res = '0;
        if (!r_sel) begin
            w_t   = {1'b0, x_in} + {1'b0, y_in} + {8'd0, r_c};
            w_u   = {1'b0, w_t[7:0]} - {1'b0, kc_in} - {8'd0, r_b};
            w_res = w_u[7:0];
        end else begin
            w_u   = {1'b0, x_in} - {1'b0, y_in} - {8'd0, r_b};
            w_t   = {1'b0, w_u[7:0]} + {1'b0, kc_in} + {8'd0, r_c};
            w_res = w_t[7:0];
        end
    end

    assign in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state == S_RUN);
    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_last  = r_out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_c         <= 1'b0;
            r_b         <= 1'b0;
            r_cnt       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_last  <= 1'b0;
        end else begin
            // A pop drains the output register; a same-cycle accept below overrides it.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_sel   <= sel;
                        r_c     <= 1'b0;
                        r_b     <= 1'b0;
                        r_cnt   <= 2'd0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_byte  <= w_res;
                        r_out_last  <= (r_cnt == 2'd3);
                        r_c         <= w_t[8];
                        r_b         <= w_u[8];
                        r_cnt       <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seed_ks_byte_arith.sv
// Self-checking bench for seed_ks_byte_arith: word-level 32-bit reference model,
// directed vectors, backpressure, reset mid-word, protocol corner cases and random words.
module tb_seed_ks_byte_arith;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] x_in = 8'h00;
    logic [7:0] y_in = 8'h00;
    logic [7:0] kc_in = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_last;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];   // {last, byte}

    always #5 clk = ~clk;

    seed_ks_byte_arith dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .kc_in(kc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .busy(busy)
    );

    function automatic logic [31:0] model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] kc);
        return s ? (x - y + kc) : (x + y - kc);
    endfunction

    // mode 0: always ready, 1: random valid/ready, 2: out_ready low 3 cycles at first out_valid
    task automatic run_word(input logic s, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] kc, input int mode, input bit hold_last,
                            input bit poke_start, input string name);
        logic [31:0] r;
        logic [8:0]  e;
        int sent = 0, cyc = 0, stall_left = 0, stalls = 0, first_pop = -1, last_pop = -1, k;
        bit stall_used = 0;
        bit pending_at_start;
        pending_at_start = (exp_q.size() != 0);
        r = model(s, x, y, kc);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), r[8*i +: 8]});
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b1; sel = s;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        while (1) begin
            if (cyc > 80) begin
                n_vec++; n_err++;
                $display("FAIL %s timeout: sent %0d beats, %0d bytes outstanding", name, sent, exp_q.size());
                break;
            end
            if (hold_last && sent == 4 && exp_q.size() == 1 && out_valid) begin
                out_ready = 1'b0;
                break;
            end
            k = (sent < 4) ? sent : 0;
            in_valid = (sent < 4) && (mode != 1 || $urandom_range(0, 3) != 0);
            x_in  = (sent < 4) ? x[8*k +: 8]  : 8'($urandom);
            y_in  = (sent < 4) ? y[8*k +: 8]  : 8'($urandom);
            kc_in = (sent < 4) ? kc[8*k +: 8] : 8'($urandom);
            start = poke_start && (sent < 3) && (cyc % 2 == 0);
            sel   = poke_start ? ~s : s;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && !stall_used) begin
                        stall_left = 3; stall_used = 1;
                    end
                    out_ready = (stall_left == 0);
                end
            endcase
            if (hold_last && exp_q.size() == 1 && sent == 4) out_ready = 1'b0;
            #1;
            if (stall_left > 0) begin
                e = exp_q[0];
                n_vec++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_byte !== e[7:0]) begin
                    n_err++;
                    $display("FAIL %s backpressure_hold: in_ready=%b out_valid=%b out_byte=%h want 0/1/%h",
                             name, in_ready, out_valid, out_byte, e[7:0]);
                end
                stall_left--;
            end
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL %s unexpected_byte: got %h want none", name, out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (out_byte !== e[7:0] || out_last !== e[8]) begin
                        n_err++;
                        $display("FAIL %s byte: got %h last=%b want %h last=%b", name, out_byte, out_last, e[7:0], e[8]);
                    end
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (!hold_last && exp_q.size() == 0) break;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; sel = s;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL %s busy_at_end: got %b want 0", name, busy);
        end
        if (mode == 0 && !pending_at_start && !hold_last) begin
            n_vec++;
            if (last_pop - first_pop != 3 || stalls != 0) begin
                n_err++;
                $display("FAIL %s throughput: pop span %0d stalls %0d want 3/0", name, last_pop - first_pop, stalls);
            end
        end
        $display("word %s sel=%0d x=%h y=%h kc=%h -> expect %h", name, s, x, y, kc, r);
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_byte !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s reset_outputs: in_ready=%b out_valid=%b out_byte=%h out_last=%b busy=%b want 0/0/00/0/0",
                     name, in_ready, out_valid, out_byte, out_last, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("power_on");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_vectors();
        run_word(1'b0, 32'h0, 32'h0, 32'h9E3779B9, 0, 0, 0, "k0_zero");
        run_word(1'b1, 32'h0, 32'h0, 32'h9E3779B9, 0, 0, 0, "k1_zero");
        run_word(1'b0, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, "k0_chain");
        run_word(1'b1, 32'h0, 32'h1, 32'h1, 0, 0, 0, "k1_chain");
    endtask

    task automatic test_backpressure();
        run_word(1'b0, 32'h0, 32'h0, 32'h9E3779B9, 2, 0, 0, "backpressure");
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        start = 1'b1; sel = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; x_in = 8'h00; y_in = 8'h00; kc_in = (i == 0) ? 8'hB9 : 8'h79;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_midop");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        run_word(1'b0, 32'h0, 32'h0, 32'h1, 0, 0, 0, "after_reset");
    endtask

    task automatic test_protocol();
        run_word(1'b0, $urandom, $urandom, $urandom, 0, 0, 1, "start_in_run");
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; x_in = 8'($urandom); y_in = 8'($urandom); kc_in = 8'($urandom);
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL idle_valid: out_valid=%b busy=%b in_ready=%b want 0/0/0", out_valid, busy, in_ready);
            end
        end
        in_valid = 1'b0;
        run_word(1'b0, 32'h0, 32'h0, 32'h9E3779B9, 0, 1, 0, "hold_last");
        run_word(1'b1, $urandom, $urandom, $urandom, 2, 0, 0, "after_pending");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_word(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1, 0, 0, "random");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_midop();
        test_protocol();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seed_ks_byte_arith.md
# seed_ks_byte_arith

Byte-serial arithmetic front end of the SEED key schedule in the 8-bit serialized datapath. It computes one 32-bit round-key pre-image, either K0 = A + C − KC or K1 = B − D + KC (mod 2^32). Operands arrive one byte per cycle, LSB first, and results leave at the same rate. The carry and borrow chains are kept internally across the four byte beats. The output byte stream feeds the G-function stage directly.

## Interface

Parameters: none (word width fixed at 32 bits = 4 bytes).

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- start  in  1  begin a new 4-byte operation; sampled only in IDLE
- sel  in  1  operation select, latched with start: 0 = X + Y − KC, 1 = X − Y + KC
- in_valid  in  1  operand byte beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- x_in  in  8  byte of A (sel=0) or B (sel=1)
- y_in  in  8  byte of C (sel=0) or D (sel=1)
- kc_in  in  8  byte of round constant KC_i
- out_valid  out  1  out_byte holds a result byte
- out_ready  in  1  downstream accepts result byte when out_valid && out_ready
- out_byte  out  8  result byte, LSB first
- out_last  out  1  qualifies out_valid: this is byte 3 (MSB)
- busy  out  1  high while in RUN

## Operation

States:
- IDLE: in_ready=0, busy=0. On start=1, go to RUN and latch sel. Clear the carry register c, the borrow register b and the byte counter cnt (2 bits).
- RUN: in_ready = !out_valid || out_ready. Each accepted beat computes the result byte, loads the output register and increments cnt. The beat with cnt==3 also sets out_last and returns the FSM to IDLE.

Per-beat arithmetic, all 9-bit with bit 8 as the chain bit:
- sel=0:
  - t = x_in + y_in + c; s = t[7:0]; c' = t[8]
  - u = {1'b0,s} − {1'b0,kc_in} − b; out = u[7:0]; b' = u[8]
- sel=1:
  - u = {1'b0,x_in} − {1'b0,y_in} − b; s = u[7:0]; b' = u[8]
  - t = s + kc_in + c; out = t[7:0]; c' = t[8]

Other rules:
- Final c/b after byte 3 are discarded, giving modulo 2^32 wrap-around.
- Output register: loads on accept and holds stable while out_valid && !out_ready. out_valid clears on out_ready when no new beat is accepted in the same cycle.
- Input beats with in_ready=0 are ignored. in_valid in IDLE is ignored.
- start in RUN is ignored; the operation cannot be restarted mid-word.
- start in IDLE while the previous last byte is still pending is legal. RUN then stalls on in_ready until that byte drains.
- rst at any time: immediate return to IDLE with all outputs at reset values. A subsequent start produces a correct result with no stale carry or borrow.

## Timing

- Reset values: in_ready=0, out_valid=0, out_byte=8'h00, out_last=0, busy=0; internal c=0, b=0, cnt=0, sel=0.
- start sampled at edge E: busy=1 and in_ready possible from E+1.
- Latency: a beat accepted at edge N is visible on out_byte/out_valid after N (1 cycle).
- Throughput: 1 byte/cycle with out_ready held high, i.e. 4 consecutive cycles per word.
- in_ready depends combinationally on out_valid/out_ready; there is no path from in_valid to in_ready.
- Simultaneous output pop and new beat accept in the same cycle: the new byte is loaded and out_valid stays 1.

## Test plan

- sel=0, A=C=0x00000000, KC=0x9E3779B9, out_ready=1 -> bytes 47,86,C8,61 on 4 consecutive cycles, out_last on 61 only.
- sel=1, B=D=0x00000000, KC=0x9E3779B9 -> bytes B9,79,37,9E.
- Chain stress, sel=0, A=0xFFFFFFFF, C=0x00000001, KC=0x00000001 -> FF,FF,FF,FF (c=1 and b=1 propagate every beat). Then sel=1, B=0x00000000, D=0x00000001, KC=0x00000001 -> 00,00,00,00.
- Backpressure: same first vector, with out_ready=0 for 3 cycles after byte 0 -> out_byte stays 47, in_ready=0, no beat lost; resuming gives 86,C8,61.
- Reset mid-op: assert rst after 2 bytes of the first vector -> all outputs reset values, busy=0. A new start with A=C=0, KC=0x00000001 -> FF,FF,FF,FF.
- Protocol: start pulsed during RUN and in_valid in IDLE -> no effect. start on the cycle after the last beat while out_ready=0 -> the last byte is held, then the next word streams correctly.
